uart_rx_pkt_ctrl: RTL

- Packet-level controller that sits directly behind uart_rx.
- Consumes uart_rx's byte stream (valid/data/err) and sequences it through a framing state machine: sync byte, length, payload, checksum.
- Forwards payload bytes downstream as a pulse stream, reports each packet's outcome with an error code, and guards against stalled links with an inter-byte timeout.
- Also maintains saturating good/bad packet statistics for the register block.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_idle_timer.sv | 31 +++
 rtl/uart_rx_pkt_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART packet controller: framing states, outcome codes
// and the running checksum width.
package uart_pkg;

   localparam int CHK_W = 8;

   typedef enum logic [3:0] {
      HUNT    = 4'b0001,
      LEN     = 4'b0010,
      PAYLOAD = 4'b0100,
      CHK     = 4'b1000
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_BAD_LEN = 3'd1,
      ERR_BAD_CHK = 3'd2,
      ERR_TIMEOUT = 3'd3,
      ERR_FRAMING = 3'd4
   } err_code_t;

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// pulses expire during the cycle in which the count reaches CYCLES-1.
module uart_idle_timer #(
   parameter int CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] count;

   // A clear in the same cycle always wins, so a byte arriving on the
   // final count suppresses the timeout.
   assign expire = en && !clr && (count == LAST);

   // Idle cycle counter; restarts after clear or after it has fired.
   always_ff @(posedge clk) begin
      if (rst || clr || expire) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framing controller behind uart_rx: SYNC, LEN, payload, CHK.
// Forwards payload bytes, reports each packet outcome and keeps
// saturating good/bad statistics.
module uart_rx_pkt_ctrl
   import uart_pkg::*;
#(
   parameter int          CLK_FREQ   = 100,
   parameter int          TIMEOUT_US = 1000,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter int          MAX_LEN    = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_err,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_last,
   output logic        pkt_done,
   output logic        pkt_ok,
   output logic [2:0]  err_code,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt
);

   localparam int         TIMEOUT_CYC = CLK_FREQ * TIMEOUT_US;
   localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);

   state_t           state, state_nx;
   logic [7:0]       rem, rem_nx;
   logic [CHK_W-1:0] chk, chk_nx;
   logic             fwd, last_nx, done_nx, ok_nx;
   err_code_t        code_nx;
   logic             in_pkt, timer_clr, expire;

   assign in_pkt    = (state != HUNT);
   assign timer_clr = rx_valid || !in_pkt;

   uart_idle_timer #(
      .CYCLES (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (timer_clr),
      .en     (in_pkt),
      .expire (expire)
   );

   // Next-state and per-byte decisions; rx_err outranks rx_valid, which
   // outranks the timeout.
   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      chk_nx   = chk;
      fwd      = 1'b0;
      last_nx  = 1'b0;
      done_nx  = 1'b0;
      ok_nx    = 1'b0;
      code_nx  = ERR_NONE;
      if (in_pkt && rx_err) begin
         done_nx  = 1'b1;
         code_nx  = ERR_FRAMING;
         state_nx = HUNT;
      end else if (rx_valid) begin
         unique case (state)
            HUNT: begin
               if (!rx_err && rx_data == SYNC_BYTE) state_nx = LEN;
            end
            LEN: begin
               if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  done_nx  = 1'b1;
                  code_nx  = ERR_BAD_LEN;
                  state_nx = HUNT;
               end else begin
                  rem_nx   = rx_data;
                  chk_nx   = rx_data;
                  state_nx = PAYLOAD;
               end
            end
            PAYLOAD: begin
               fwd    = 1'b1;
               chk_nx = chk + rx_data;
               rem_nx = rem - 8'd1;
               if (rem == 8'd1) begin
                  last_nx  = 1'b1;
                  state_nx = CHK;
               end
            end
            CHK: begin
               done_nx  = 1'b1;
               ok_nx    = (rx_data == chk);
               code_nx  = (rx_data == chk) ? ERR_NONE : ERR_BAD_CHK;
               state_nx = HUNT;
            end
            default: state_nx = HUNT;
         endcase
      end else if (expire) begin
         done_nx  = 1'b1;
         code_nx  = ERR_TIMEOUT;
         state_nx = HUNT;
      end
   end

   // State, checksum, registered stream/outcome outputs and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         rem      <= '0;
         chk      <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
         pkt_done <= 1'b0;
         pkt_ok   <= 1'b0;
         err_code <= '0;
         pkt_cnt  <= '0;
         err_cnt  <= '0;
      end else begin
         state    <= state_nx;
         rem      <= rem_nx;
         chk      <= chk_nx;
         m_valid  <= fwd;
         if (fwd) m_data <= rx_data;
         m_last   <= last_nx;
         pkt_done <= done_nx;
         pkt_ok   <= ok_nx;
         err_code <= code_nx;
         if (done_nx && ok_nx && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
         if (done_nx && !ok_nx && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
   end

endmodule
